axis_demux_2_32: RTL and testbench

// - AXI4-Stream 1-to-2 frame demultiplexer; the counterpart of the 2-port arbitrated mux on the fan-out side.
// - Steers each whole frame from one input stream to one of two output streams.
// - Port is selected by `select`, sampled at the first beat of the frame and held until tlast.
// - Registered output with skid buffer: full throughput, one cycle of latency.

---
 rtl/axis_demux_2_32.sv | 187 ++++++++++++++++++
 tb/tb_axis_demux_2_32.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_2_32.sv
// axis_demux_2_32: AXI4-Stream 1-to-2 frame demultiplexer; the port is chosen by select at the frame's first beat.
// Latency: one clock from input transfer to output tvalid; sustains 1 beat/clk through output register + skid.
// Backpressure: input_axis_tready is registered and drops once output register and skid both hold a beat.
// Optional macro AXIS_DEMUX_DROP_EN: frames that start while enable=0 are consumed and discarded.
module axis_demux_2_32 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
  output logic                  output_0_axis_tvalid,
  input  logic                  output_0_axis_tready,
  output logic                  output_0_axis_tlast,
  output logic                  output_0_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
  output logic                  output_1_axis_tvalid,
  input  logic                  output_1_axis_tready,
  output logic                  output_1_axis_tlast,
  output logic                  output_1_axis_tuser,
  input  logic                  enable,
  input  logic                  select
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_sel;
  logic                  r_in_rdy;

  // Output register: one beat plus the port it is destined for.
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic                  r_out_vld;
  logic                  r_out_sel;
  logic                  r_out_last;
  logic                  r_out_user;

  // Skid register: parks the beat accepted while the output register is stalled.
  logic [DATA_WIDTH-1:0] r_tmp_dat;
  logic                  r_tmp_vld;
  logic                  r_tmp_sel;
  logic                  r_tmp_last;
  logic                  r_tmp_user;

  logic                  w_in_rdy;
  logic                  w_in_xfer;
  logic                  w_in_acc;
  logic                  w_beat_sel;
  logic                  w_out_xfer;
  logic [1:0]            w_cnt_next;

  // State register; the destination port is latched when a frame starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && input_axis_tvalid && enable) begin
        r_sel <= select;
      end
    end
  end

  // Next-state: a single-beat frame starts and ends in the same IDLE cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (input_axis_tvalid && enable) begin
          w_state_next = (w_in_xfer && input_axis_tlast) ? S_IDLE : S_ROUTE;
        end
`ifdef AXIS_DEMUX_DROP_EN
        else if (input_axis_tvalid) begin
          w_state_next = S_DROP;
        end
`endif
      end
      S_ROUTE: begin
        if (w_in_xfer && input_axis_tlast) begin
          w_state_next = S_IDLE;
        end
      end
`ifdef AXIS_DEMUX_DROP_EN
      S_DROP: begin
        if (w_in_xfer && input_axis_tlast) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM outputs: input ready gating and the port of the beat being accepted.
  always_comb begin
    w_in_rdy   = 1'b0;
    w_beat_sel = r_sel;
    case (r_state)
      S_IDLE: begin
        w_in_rdy   = r_in_rdy & enable;
        w_beat_sel = select;
      end
      S_ROUTE: w_in_rdy = r_in_rdy;
`ifdef AXIS_DEMUX_DROP_EN
      S_DROP:  w_in_rdy = 1'b1;
`endif
      default: w_in_rdy = 1'b0;
    endcase
    w_in_xfer = input_axis_tvalid & w_in_rdy;
    w_in_acc  = w_in_xfer & (r_state != S_DROP);
  end

  assign w_out_xfer = r_out_vld & (r_out_sel ? output_1_axis_tready : output_0_axis_tready);

  // Beats held after this cycle; ready stays high while there is room for one more.
  assign w_cnt_next = {1'b0, r_out_vld} + {1'b0, r_tmp_vld} + {1'b0, w_in_acc} - {1'b0, w_out_xfer};

  // Output register and skid: refill the output from skid first so frame order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_rdy   <= 1'b0;
      r_out_dat  <= '0;
      r_out_vld  <= 1'b0;
      r_out_sel  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_user <= 1'b0;
      r_tmp_dat  <= '0;
      r_tmp_vld  <= 1'b0;
      r_tmp_sel  <= 1'b0;
      r_tmp_last <= 1'b0;
      r_tmp_user <= 1'b0;
    end else begin
      r_in_rdy <= (w_cnt_next < 2'd2);
      if (!r_out_vld || w_out_xfer) begin
        if (r_tmp_vld) begin
          r_out_dat  <= r_tmp_dat;
          r_out_vld  <= 1'b1;
          r_out_sel  <= r_tmp_sel;
          r_out_last <= r_tmp_last;
          r_out_user <= r_tmp_user;
          r_tmp_vld  <= w_in_acc;
          if (w_in_acc) begin
            r_tmp_dat  <= input_axis_tdata;
            r_tmp_sel  <= w_beat_sel;
            r_tmp_last <= input_axis_tlast;
            r_tmp_user <= input_axis_tuser;
          end
        end else begin
          r_out_vld <= w_in_acc;
          if (w_in_acc) begin
            r_out_dat  <= input_axis_tdata;
            r_out_sel  <= w_beat_sel;
            r_out_last <= input_axis_tlast;
            r_out_user <= input_axis_tuser;
          end
        end
      end else if (w_in_acc) begin
        r_tmp_vld  <= 1'b1;
        r_tmp_dat  <= input_axis_tdata;
        r_tmp_sel  <= w_beat_sel;
        r_tmp_last <= input_axis_tlast;
        r_tmp_user <= input_axis_tuser;
      end
    end
  end

  assign input_axis_tready    = w_in_rdy;
  assign output_0_axis_tdata  = r_out_dat;
  assign output_0_axis_tvalid = r_out_vld & ~r_out_sel;
  assign output_0_axis_tlast  = r_out_last;
  assign output_0_axis_tuser  = r_out_user;
  assign output_1_axis_tdata  = r_out_dat;
  assign output_1_axis_tvalid = r_out_vld & r_out_sel;
  assign output_1_axis_tlast  = r_out_last;
  assign output_1_axis_tuser  = r_out_user;

endmodule

// File: tb/tb_axis_demux_2_32.sv
// Bench for axis_demux_2_32: directed frames plus a random-traffic run checked against a global
// ordered scoreboard holding {port, last, user, data} for every accepted beat.
module tb_axis_demux_2_32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_dat;
  logic       in_vld, in_last, in_user;
  logic       in_rdy;
  logic [7:0] out0_dat, out1_dat;
  logic       out0_vld, out1_vld, out0_last, out1_last, out0_user, out1_user;
  logic       rdy0, rdy1;
  logic       en_i, sel_i;

  typedef struct packed {
    logic       port;
    logic       last;
    logic       user;
    logic [7:0] dat;
  } beat_t;

  beat_t sb[$];
  beat_t exp_b;
  int    errors = 0;
  int    checks = 0;
  int    in_cnt = 0;
  bit    tb_sel = 1'b0;
  bit    tb_drop = 1'b0;
  bit    rnd_rdy = 1'b0;
  int    c0, c1, n;

  logic       o_vld[2], o_rdy[2], o_last[2], o_user[2];
  logic [7:0] o_dat[2];
  logic       p_stall[2], p_last[2], p_user[2];
  logic [7:0] p_dat[2];

  assign o_vld[0] = out0_vld;  assign o_vld[1] = out1_vld;
  assign o_rdy[0] = rdy0;      assign o_rdy[1] = rdy1;
  assign o_last[0] = out0_last; assign o_last[1] = out1_last;
  assign o_user[0] = out0_user; assign o_user[1] = out1_user;
  assign o_dat[0] = out0_dat;  assign o_dat[1] = out1_dat;

  always #5 clk = ~clk;

  axis_demux_2_32 #(.DATA_WIDTH(8)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_axis_tdata     (in_dat),
    .input_axis_tvalid    (in_vld),
    .input_axis_tready    (in_rdy),
    .input_axis_tlast     (in_last),
    .input_axis_tuser     (in_user),
    .output_0_axis_tdata  (out0_dat),
    .output_0_axis_tvalid (out0_vld),
    .output_0_axis_tready (rdy0),
    .output_0_axis_tlast  (out0_last),
    .output_0_axis_tuser  (out0_user),
    .output_1_axis_tdata  (out1_dat),
    .output_1_axis_tvalid (out1_vld),
    .output_1_axis_tready (rdy1),
    .output_1_axis_tlast  (out1_last),
    .output_1_axis_tuser  (out1_user),
    .enable               (en_i),
    .select               (sel_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: outputs are popped before the input push of the same edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      p_stall[0] = 1'b0;
      p_stall[1] = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (p_stall[p])
          check($sformatf("hold_p%0d", p), 32'({o_vld[p], o_last[p], o_user[p], o_dat[p]}),
                32'({1'b1, p_last[p], p_user[p], p_dat[p]}));
        if (o_vld[p] && o_rdy[p]) begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL extra_beat_p%0d: observed=%0h expected=none", p, o_dat[p]);
          end
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check($sformatf("out_beat_p%0d", p), 32'({p[0], o_last[p], o_user[p], o_dat[p]}), 32'(exp_b));
          end
        end
        p_stall[p] = o_vld[p] && !o_rdy[p];
        p_last[p]  = o_last[p];
        p_user[p]  = o_user[p];
        p_dat[p]   = o_dat[p];
      end
      if (in_vld && in_rdy) begin
        in_cnt++;
        if (!tb_drop) sb.push_back({tb_sel, in_last, in_user, in_dat});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      rdy0 = ($urandom_range(99) < 70);
      rdy1 = ($urandom_range(99) < 70);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u, input logic s, input logic e);
    int  k = 0;
    bit  hs = 1'b0;
    in_vld = 1'b1; in_dat = d; in_last = l; in_user = u; sel_i = s; en_i = e;
    while (!hs && k < 300) begin
      @(negedge clk);
      hs = in_rdy;
      tick();
      k++;
    end
    checks++;
    assert (hs) else begin
      errors++;
      $error("FAIL beat_timeout: observed=no_handshake expected=handshake data=%0h", d);
    end
  endtask

  task automatic send_frame(input int len, input logic s, input logic e, input logic tog,
                            input int gap, input logic [7:0] base);
    tb_sel  = s;
    tb_drop = !e;
    for (int b = 0; b < len; b++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        in_vld = 1'b0;
        tick();
      end
      send_beat(8'(base + 8'(b)), (b == len - 1), 1'($urandom_range(1)),
                (tog && b > 0) ? !s : s, (tog && b > 0) ? !e : e);
    end
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 500) begin
      tick();
      k++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_dat = 8'h00; in_last = 1'b0; in_user = 1'b0;
    rdy0 = 1'b1; rdy1 = 1'b1; en_i = 1'b1; sel_i = 1'b0;

    // Reset state
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'd0);
    check("rst_out0_vld", 32'(out0_vld), 32'd0);
    check("rst_out1_vld", 32'(out1_vld), 32'd0);
    check("rst_out0_last_user", 32'({out0_last, out0_user}), 32'd0);
    check("rst_out1_last_user", 32'({out1_last, out1_user}), 32'd0);
    check("rst_out0_dat", 32'(out0_dat), 32'd0);
    check("rst_out1_dat", 32'(out1_dat), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // 4-beat frame to port 0: one-cycle latency, back-to-back beats, port 1 silent
    tb_sel = 1'b0; tb_drop = 1'b0;
    for (int b = 0; b < 4; b++) begin
      in_vld = 1'b1; in_dat = 8'(8'h11 + b); in_last = (b == 3); in_user = 1'b0;
      sel_i = 1'b0; en_i = 1'b1;
      @(negedge clk);
      check("t1_in_rdy", 32'(in_rdy), 32'd1);
      if (b > 0) begin
        check("t1_out0_vld", 32'(out0_vld), 32'd1);
        check("t1_out0_dat", 32'(out0_dat), 32'(8'h11 + b - 1));
        check("t1_out1_vld", 32'(out1_vld), 32'd0);
      end
      tick();
    end
    in_vld = 1'b0;
    @(negedge clk);
    check("t1_last_beat", 32'({out0_vld, out1_vld, out0_last, out0_dat}), 32'({3'b101, 8'h14}));
    tick();
    @(negedge clk);
    check("t1_out0_idle", 32'(out0_vld), 32'd0);
    tick();

    // Frame A to port 1 then frame B to port 0 back-to-back, select/enable toggled mid-frame
    send_frame(3, 1'b1, 1'b1, 1'b1, 0, 8'hA0);
    send_frame(2, 1'b0, 1'b1, 1'b1, 0, 8'hB0);
    drain();

    // Port 0 stalled for 5 clocks in the middle of a 6-beat frame
    c0 = in_cnt;
    fork
      send_frame(6, 1'b0, 1'b1, 1'b0, 0, 8'h30);
      begin
        n = 0;
        while (in_cnt < c0 + 2 && n < 50) begin
          tick();
          n++;
        end
        rdy0 = 1'b0;
        c1 = in_cnt;
        tick();
        check("t3_in_rdy_drop", 32'(in_rdy), 32'd0);
        repeat (4) begin
          tick();
          check("t3_out0_held", 32'(out0_vld), 32'd1);
        end
        check("t3_skid_one_beat", 32'(in_cnt - c1), 32'd1);
        rdy0 = 1'b1;
      end
    join
    drain();
    check("t3_total_beats", 32'(in_cnt - c0), 32'd6);

    // enable=0 with a pending frame
`ifdef AXIS_DEMUX_DROP_EN
    c1 = in_cnt;
    send_frame(4, 1'b1, 1'b0, 1'b1, 0, 8'h50);
    tick(); tick();
    check("t4_drop_consumed", 32'(in_cnt - c1), 32'd4);
    check("t4_drop_no_out", 32'({out0_vld, out1_vld}), 32'd0);
    check("t4_drop_sb_empty", 32'(sb.size()), 32'd0);
`else
    in_vld = 1'b1; in_dat = 8'h50; in_last = 1'b0; in_user = 1'b0; sel_i = 1'b1; en_i = 1'b0;
    tb_sel = 1'b1; tb_drop = 1'b0;
    c1 = in_cnt;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_in_rdy", 32'(in_rdy), 32'd0);
      check("t4_stall_out_vld", 32'({out0_vld, out1_vld}), 32'd0);
      tick();
    end
    check("t4_stall_no_xfer", 32'(in_cnt - c1), 32'd0);
`endif
    send_frame(3, 1'b1, 1'b1, 1'b0, 0, 8'h50);
    drain();

    // Reset during beat 2 of a 5-beat frame
    tb_sel = 1'b0; tb_drop = 1'b0;
    send_beat(8'h60, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(8'h61, 1'b0, 1'b0, 1'b0, 1'b1);
    in_dat = 8'h62;
    rst = 1'b1;
    #1;
    check("t5_rst_in_rdy", 32'(in_rdy), 32'd0);
    check("t5_rst_out_vld", 32'({out0_vld, out1_vld}), 32'd0);
    in_vld = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    send_frame(3, 1'b1, 1'b1, 1'b0, 0, 8'h70);
    drain();

    // Random traffic: 1000 frames, random length/port/gaps/ready
    rnd_rdy = 1'b1;
    for (int f = 0; f < 1000; f++)
      send_frame($urandom_range(16, 1), 1'($urandom_range(1)), 1'b1, 1'($urandom_range(1)), 30, 8'($urandom));
    rnd_rdy = 1'b0;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
